// File: rtl/miss_mc_pkg.sv
// Shared types for the multi-channel MoldUDP64 missed-message detector.
// Record fields are sized for the default widths; top-level widths must not exceed them.
package miss_mc_pkg;

    localparam int REC_CH_W  = 8;
    localparam int REC_SID_W = 80;
    localparam int REC_SEQ_W = 64;

    typedef enum logic {GAP_SEQ = 1'b0, GAP_SID = 1'b1} gap_kind_e;

    typedef enum logic [1:0] {ST_INIT, ST_LIVE, ST_EOS} ch_st_e;

    typedef struct packed {
        gap_kind_e              kind;
        logic [REC_CH_W-1:0]    ch;
        logic [REC_SID_W-1:0]   sid_start;
        logic [REC_SEQ_W-1:0]   seq_start;
        logic [REC_SID_W-1:0]   sid_cnt;
        logic [REC_SEQ_W-1:0]   seq_end;
    } gap_rec_t;

endpackage

// File: rtl/miss_msg_det_mc_gap_fifo.sv
// First-word-fall-through FIFO of gap records; a push into a full FIFO is
// accepted when a pop happens in the same cycle, otherwise it is dropped.
module gap_fifo
    import miss_mc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  gap_rec_t wdata,
    input  logic     pop,
    output gap_rec_t rdata,
    output logic     empty,
    output logic     full,
    output logic     drop
);
    localparam int AW = $clog2(DEPTH);

    gap_rec_t       mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           wr_en;
    logic           rd_en;

    // Extra pointer bit distinguishes full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign drop  = push && !wr_en;
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/miss_msg_det_mc.sv
// Per-channel session/sequence tracker: turns MoldUDP64 header discontinuities
// into gap records queued for the retransmission requester.
module miss_msg_det_mc
    import miss_mc_pkg::*;
#(
    parameter int                 CH_N        = 2,
    parameter int                 CH_W        = $clog2(CH_N),
    parameter int                 SEQ_NUM_W   = 64,
    parameter int                 SID_W       = 80,
    parameter int                 ML_W        = 16,
    parameter logic [SEQ_NUM_W-1:0] SEQ_START = '0,
    parameter logic [SID_W-1:0]   SID_GAP_MAX = SID_W'(65536),
    parameter int                 FIFO_D      = 4
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 v_i,
    input  logic [CH_W-1:0]      ch_i,
    input  logic [SID_W-1:0]     sid_i,
    input  logic [SEQ_NUM_W-1:0] seq_num_i,
    input  logic [ML_W-1:0]      msg_cnt_i,
    input  logic                 eos_i,
    output logic                 gap_v_o,
    input  logic                 gap_ready_i,
    output logic                 gap_kind_o,
    output logic [CH_W-1:0]      gap_ch_o,
    output logic [SID_W-1:0]     gap_sid_start_o,
    output logic [SEQ_NUM_W-1:0] gap_seq_start_o,
    output logic [SID_W-1:0]     gap_sid_cnt_o,
    output logic [SEQ_NUM_W-1:0] gap_seq_end_o,
    output logic                 dup_o,
    output logic                 resync_o,
    output logic                 ovf_o
);
    ch_st_e               st_q  [CH_N];
    logic [SID_W-1:0]     sid_q [CH_N];
    logic [SEQ_NUM_W-1:0] exp_q [CH_N];

    ch_st_e               st_c, st_n, st_adopt;
    logic [SID_W-1:0]     sid_c, sid_n, sid_diff;
    logic [SEQ_NUM_W-1:0] exp_c, exp_n, seq_end;
    logic                 sid_fwd, sid_far;
    logic                 upd, push, dup, rsy;
    gap_rec_t             rec, head;
    logic                 fifo_empty, fifo_full, fifo_drop;

    assign st_c     = st_q[ch_i];
    assign sid_c    = sid_q[ch_i];
    assign exp_c    = exp_q[ch_i];
    assign seq_end  = seq_num_i + SEQ_NUM_W'(msg_cnt_i);
    assign sid_diff = sid_i - sid_c;
    assign sid_fwd  = sid_i > sid_c;
    assign sid_far  = sid_fwd && (sid_diff > SID_GAP_MAX);
    assign st_adopt = eos_i ? ST_EOS : ST_LIVE;

    always_comb begin
        upd    = 1'b0;
        st_n   = st_c;
        sid_n  = sid_c;
        exp_n  = exp_c;
        push   = 1'b0;
        dup    = 1'b0;
        rsy    = 1'b0;
        rec    = '0;
        rec.ch = REC_CH_W'(ch_i);
        if (v_i) begin
            if (st_c == ST_INIT) begin
                upd   = 1'b1;
                st_n  = st_adopt;
                sid_n = sid_i;
                exp_n = seq_end;
            end else if (!sid_fwd && sid_i != sid_c) begin
                dup = 1'b1;
            end else if (sid_far) begin
                rsy   = 1'b1;
                upd   = 1'b1;
                st_n  = st_adopt;
                sid_n = sid_i;
                exp_n = seq_end;
            end else if (st_c == ST_LIVE) begin
                if (sid_i == sid_c) begin
                    // Anything reaching past exp_q advances it; fully stale data is a dup.
                    if (seq_num_i >= exp_c || seq_end > exp_c) begin
                        upd   = 1'b1;
                        st_n  = st_adopt;
                        exp_n = seq_end;
                        if (seq_num_i > exp_c) begin
                            push          = 1'b1;
                            rec.kind      = GAP_SEQ;
                            rec.sid_start = REC_SID_W'(sid_c);
                            rec.seq_start = REC_SEQ_W'(exp_c);
                            rec.seq_end   = REC_SEQ_W'(seq_num_i);
                        end
                    end else begin
                        dup = 1'b1;
                    end
                end else begin
                    push          = 1'b1;
                    rec.kind      = GAP_SID;
                    rec.sid_start = REC_SID_W'(sid_c);
                    rec.seq_start = REC_SEQ_W'(exp_c);
                    rec.sid_cnt   = REC_SID_W'(sid_diff);
                    rec.seq_end   = REC_SEQ_W'(seq_num_i);
                    upd           = 1'b1;
                    st_n          = st_adopt;
                    sid_n         = sid_i;
                    exp_n         = seq_end;
                end
            end else if (sid_i == sid_c) begin
                // Ended session: EOS heartbeats are silent, data for it is stale.
                dup = !eos_i;
            end else begin
                upd   = 1'b1;
                st_n  = st_adopt;
                sid_n = sid_i;
                exp_n = seq_end;
                if (sid_diff == SID_W'(1)) begin
                    if (seq_num_i > SEQ_START) begin
                        push          = 1'b1;
                        rec.kind      = GAP_SEQ;
                        rec.sid_start = REC_SID_W'(sid_i);
                        rec.seq_start = REC_SEQ_W'(SEQ_START);
                        rec.seq_end   = REC_SEQ_W'(seq_num_i);
                    end
                end else begin
                    push          = 1'b1;
                    rec.kind      = GAP_SID;
                    rec.sid_start = REC_SID_W'(sid_c + SID_W'(1));
                    rec.seq_start = REC_SEQ_W'(SEQ_START);
                    rec.sid_cnt   = REC_SID_W'(sid_diff - SID_W'(1));
                    rec.seq_end   = REC_SEQ_W'(seq_num_i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (nreset) begin
            for (int i = 0; i < CH_N; i++) begin
                st_q[i]  <= ST_INIT;
                sid_q[i] <= '0;
                exp_q[i] <= '0;
            end
            dup_o    <= 1'b0;
            resync_o <= 1'b0;
            ovf_o    <= 1'b0;
        end else begin
            if (upd) begin
                st_q[ch_i]  <= st_n;
                sid_q[ch_i] <= sid_n;
                exp_q[ch_i] <= exp_n;
            end
            dup_o    <= dup;
            resync_o <= rsy;
            if (fifo_drop) begin
                ovf_o <= 1'b1;
            end
        end
    end

    gap_fifo #(.DEPTH(FIFO_D)) u_gap_fifo (
        .clk   (clk),
        .rst   (nreset),
        .push  (push),
        .wdata (rec),
        .pop   (gap_ready_i),
        .rdata (head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .drop  (fifo_drop)
    );

    logic unused_fifo_bits;
    assign unused_fifo_bits = fifo_full ^ (^head.ch);

    assign gap_v_o         = !fifo_empty;
    assign gap_kind_o      = head.kind;
    assign gap_ch_o        = head.ch[CH_W-1:0];
    assign gap_sid_start_o = head.sid_start[SID_W-1:0];
    assign gap_seq_start_o = head.seq_start[SEQ_NUM_W-1:0];
    assign gap_sid_cnt_o   = head.sid_cnt[SID_W-1:0];
    assign gap_seq_end_o   = head.seq_end[SEQ_NUM_W-1:0];

endmodule

// File: tb/tb_miss_msg_det_mc.sv
// Directed bench for miss_msg_det_mc: a vector table for single-header behaviour
// plus hand sequences for back-pressure, overflow and mid-stream reset.
module tb_miss_msg_det_mc;
    import miss_mc_pkg::*;

    logic        clk = 1'b0;
    logic        nreset, v_i, eos_i, gap_ready_i;
    logic [0:0]  ch_i;
    logic [79:0] sid_i;
    logic [63:0] seq_num_i;
    logic [15:0] msg_cnt_i;
    logic        gap_v_o, gap_kind_o, dup_o, resync_o, ovf_o;
    logic [0:0]  gap_ch_o;
    logic [79:0] gap_sid_start_o, gap_sid_cnt_o;
    logic [63:0] gap_seq_start_o, gap_seq_end_o;

    int checks = 0;
    int failures = 0;

    miss_msg_det_mc dut (
        .clk(clk), .nreset(nreset), .v_i(v_i), .ch_i(ch_i), .sid_i(sid_i),
        .seq_num_i(seq_num_i), .msg_cnt_i(msg_cnt_i), .eos_i(eos_i),
        .gap_v_o(gap_v_o), .gap_ready_i(gap_ready_i), .gap_kind_o(gap_kind_o),
        .gap_ch_o(gap_ch_o), .gap_sid_start_o(gap_sid_start_o),
        .gap_seq_start_o(gap_seq_start_o), .gap_sid_cnt_o(gap_sid_cnt_o),
        .gap_seq_end_o(gap_seq_end_o), .dup_o(dup_o), .resync_o(resync_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ch;
        logic [79:0] sid;
        logic [63:0] seq;
        logic [15:0] cnt;
        logic        eos;
        logic        e_v;
        logic        e_kind;
        logic [79:0] e_sid;
        logic [63:0] e_seq;
        logic [79:0] e_cnt;
        logic [63:0] e_end;
        logic        e_dup;
        logic        e_rsy;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(logic ch, logic [79:0] sid, logic [63:0] seq, logic [15:0] cnt,
                                logic eos, logic e_v, logic e_kind, logic [79:0] e_sid,
                                logic [63:0] e_seq, logic [79:0] e_cnt, logic [63:0] e_end,
                                logic e_dup, logic e_rsy);
        vec_t r;
        r.ch = ch; r.sid = sid; r.seq = seq; r.cnt = cnt; r.eos = eos;
        r.e_v = e_v; r.e_kind = e_kind; r.e_sid = e_sid; r.e_seq = e_seq;
        r.e_cnt = e_cnt; r.e_end = e_end; r.e_dup = e_dup; r.e_rsy = e_rsy;
        return r;
    endfunction

    function automatic logic [289:0] head_now();
        return {gap_kind_o, gap_ch_o, gap_sid_start_o, gap_seq_start_o, gap_sid_cnt_o, gap_seq_end_o};
    endfunction

    function automatic logic [289:0] rec(logic kind, logic ch, logic [79:0] s, logic [63:0] q,
                                         logic [79:0] c, logic [63:0] e);
        return {kind, ch, s, q, c, e};
    endfunction

    task automatic chk(string nm, logic [289:0] act, logic [289:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic send(logic ch, logic [79:0] sid, logic [63:0] seq, logic [15:0] cnt, logic eos);
        v_i = 1'b1; ch_i = ch; sid_i = sid; seq_num_i = seq; msg_cnt_i = cnt; eos_i = eos;
        @(posedge clk);
        #1;
        v_i = 1'b0;
    endtask

    initial begin
        nreset = 1'b1; v_i = 1'b0; ch_i = '0; sid_i = '0; seq_num_i = '0;
        msg_cnt_i = '0; eos_i = 1'b0; gap_ready_i = 1'b1;

        vecs[0]  = mk(0, 5, 0, 3, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 5, 3, 2, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 5, 5, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(0, 5, 10, 2, 0, 1, 0, 5, 6, 0, 10, 0, 0);
        vecs[4]  = mk(1, 7, 0, 4, 1,  0, 0, 0, 0, 0, 0, 0, 0);
        vecs[5]  = mk(1, 9, 4, 1, 0,  1, 1, 8, 0, 1, 4, 0, 0);
        vecs[6]  = mk(1, 9, 0, 2, 0,  0, 0, 0, 0, 0, 0, 1, 0);
        vecs[7]  = mk(0, 5, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[8]  = mk(1, 9, 5, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        vecs[9]  = mk(0, 5, 13, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[10] = mk(1, 9, 8, 1, 0,  1, 0, 9, 6, 0, 8, 0, 0);
        vecs[11] = mk(0, 5, 15, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[12] = mk(0, 5, 14, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[13] = mk(0, 5, 18, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[14] = mk(0, 5, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0);
        vecs[15] = mk(0, 6, 0, 3, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        vecs[16] = mk(0, 6, 3, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0);
        vecs[17] = mk(0, 7, 2, 1, 0,  1, 0, 7, 0, 0, 2, 0, 0);
        vecs[18] = mk(0, 9, 1, 2, 0,  1, 1, 7, 3, 2, 1, 0, 0);
        vecs[19] = mk(0, 4, 3, 1, 0,  0, 0, 0, 0, 0, 0, 1, 0);
        vecs[20] = mk(0, 80'd65546, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        vecs[21] = mk(0, 80'd131082, 5, 1, 0, 1, 1, 80'd65546, 1, 80'd65536, 5, 0, 0);
        vecs[22] = mk(1, 9, 64'hFFFF_FFFF_FFFF_FFFE, 3, 0, 1, 0, 9, 9, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0);
        vecs[23] = mk(1, 9, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        nreset = 1'b0;
        chk("rst_gap_v", gap_v_o, 0);
        chk("rst_dup", dup_o, 0);
        chk("rst_resync", resync_o, 0);
        chk("rst_ovf", ovf_o, 0);
        chk("rst_st0", dut.st_q[0], ST_INIT);
        chk("rst_st1", dut.st_q[1], ST_INIT);

        for (int i = 0; i < 24; i++) begin
            send(vecs[i].ch, vecs[i].sid, vecs[i].seq, vecs[i].cnt, vecs[i].eos);
            chk($sformatf("v%0d_gap_v", i), gap_v_o, vecs[i].e_v);
            chk($sformatf("v%0d_dup", i), dup_o, vecs[i].e_dup);
            chk($sformatf("v%0d_resync", i), resync_o, vecs[i].e_rsy);
            if (vecs[i].e_v)
                chk($sformatf("v%0d_rec", i), head_now(),
                    rec(vecs[i].e_kind, vecs[i].ch, vecs[i].e_sid, vecs[i].e_seq,
                        vecs[i].e_cnt, vecs[i].e_end));
        end
        chk("exp_q0_final", dut.exp_q[0], 6);

        // Back-pressure: ch1 (sid 9, exp 2) produces five gaps with no consumer.
        gap_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send(1, 9, 64'(4 + 3 * k), 1, 0);
            chk($sformatf("bp%0d_ovf", k), ovf_o, (k == 4));
        end
        chk("bp_head_held", head_now(), rec(0, 1, 9, 2, 0, 4));

        // Push into a full FIFO while popping: accepted, ovf stays sticky.
        gap_ready_i = 1'b1;
        send(1, 9, 19, 1, 0);
        chk("pp_ovf_sticky", ovf_o, 1);
        for (int j = 0; j < 4; j++) begin
            logic [63:0] st;
            logic [63:0] en;
            st = (j < 3) ? 64'(5 + 3 * j) : 64'd17;
            en = st + 64'd2;
            chk($sformatf("drain%0d_v", j), gap_v_o, 1);
            chk($sformatf("drain%0d_rec", j), head_now(), rec(0, 1, 9, st, 0, en));
            @(posedge clk);
            #1;
        end
        chk("drain_empty", gap_v_o, 0);

        // Mid-stream reset with two records queued.
        gap_ready_i = 1'b0;
        send(1, 9, 22, 1, 0);
        send(1, 9, 25, 1, 0);
        chk("pre_rst_v", gap_v_o, 1);
        nreset = 1'b1;
        @(posedge clk);
        #1;
        nreset = 1'b0;
        chk("mrst_gap_v", gap_v_o, 0);
        chk("mrst_ovf", ovf_o, 0);
        chk("mrst_st0", dut.st_q[0], ST_INIT);
        chk("mrst_st1", dut.st_q[1], ST_INIT);
        send(0, 3, 50, 1, 0);
        chk("post_init_v", gap_v_o, 0);
        chk("post_init_dup", dup_o, 0);
        send(0, 3, 60, 1, 0);
        chk("post_gap_rec", head_now(), rec(0, 0, 3, 51, 0, 60));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
